// File: rtl/signal_switch_ctrl_pkg.sv
// signal_switch_pkg: shared definitions for the signal_switch controller.
//   - state_e     : controller FSM states
//   - DEF_*_WIDTH : default widths for datapath, settle count and auto period
//   - COUNT_WIDTH : width of the completed-switch counter
package signal_switch_pkg;
  localparam int DEF_DATA_WIDTH   = 16;
  localparam int DEF_SETTLE_WIDTH = 16;
  localparam int DEF_PERIOD_WIDTH = 32;
  localparam int COUNT_WIDTH      = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_SETTLE = 2'd2
  } state_e;
endpackage

// File: rtl/signal_switch_ctrl_if.sv
// signal_switch_ctrl_if: request / status bundle of the switch controller.
//   master : requester side (drives req_valid, req_sel, settle_cycles)
//   slave  : controller side (drives req_ready, switch, blank, busy, switch_count)
// With SIGNAL_SWITCH_CTRL_AUTO_EN defined the bundle also carries auto_en and
// auto_period, driven by the master.
interface signal_switch_ctrl_if #(
  parameter int SETTLE_WIDTH = 16,
  parameter int PERIOD_WIDTH = 32
);
  if (SETTLE_WIDTH < 1 || PERIOD_WIDTH < 1) begin : g_bad_width
    $error("signal_switch_ctrl_if: widths must be positive");
  end

  logic                    req_valid;
  logic                    req_sel;
  logic                    req_ready;
  logic [SETTLE_WIDTH-1:0] settle_cycles;
  logic                    switch;
  logic                    blank;
  logic                    busy;
  logic [15:0]             switch_count;
`ifdef SIGNAL_SWITCH_CTRL_AUTO_EN
  logic                    auto_en;
  logic [PERIOD_WIDTH-1:0] auto_period;
`endif

  modport master (
    output req_valid, req_sel, settle_cycles,
`ifdef SIGNAL_SWITCH_CTRL_AUTO_EN
    output auto_en, auto_period,
`endif
    input  req_ready, switch, blank, busy, switch_count
  );

  modport slave (
    input  req_valid, req_sel, settle_cycles,
`ifdef SIGNAL_SWITCH_CTRL_AUTO_EN
    input  auto_en, auto_period,
`endif
    output req_ready, switch, blank, busy, switch_count
  );
endinterface

// File: rtl/signal_switch_ctrl_period_timer.sv
// switch_period_timer: auto-toggle period counter (present only when
// SIGNAL_SWITCH_CTRL_AUTO_EN is defined).
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_en         : count enable (auto enabled and controller idle/ready)
//   i_clr        : a request was accepted this cycle
//   i_period     : period in cycles; 0 disables firing
//   o_fire       : internal request strobe on the last cycle of the period
`ifdef SIGNAL_SWITCH_CTRL_AUTO_EN
module switch_period_timer #(
  parameter int PERIOD_WIDTH = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic                    i_clr,
  input  logic [PERIOD_WIDTH-1:0] i_period,
  output logic                    o_fire
);
  logic [PERIOD_WIDTH-1:0] r_cnt;

  assign o_fire = i_en && (i_period != '0) && (r_cnt == i_period - PERIOD_WIDTH'(1));

  // Any accepted request (including the one o_fire produces) restarts the period.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en || i_clr) r_cnt <= '0;
    else                         r_cnt <= r_cnt + PERIOD_WIDTH'(1);
  end
endmodule
`endif

// File: rtl/signal_switch_ctrl.sv
// signal_switch_ctrl: sequences a source change on signal_switch with blanking.
//   SYS_aclk  : clock (rising edge)
//   SYS_reset : synchronous active-high reset
//   bus       : signal_switch_ctrl_if.slave (request in, switch/blank/status out)
// Optional feature macro: SIGNAL_SWITCH_CTRL_AUTO_EN adds periodic auto-toggle
// requests (auto_en / auto_period) via switch_period_timer.
module signal_switch_ctrl
  import signal_switch_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int SETTLE_WIDTH = DEF_SETTLE_WIDTH,
  parameter int PERIOD_WIDTH = DEF_PERIOD_WIDTH
) (
  input logic                 SYS_aclk,
  input logic                 SYS_reset,
  signal_switch_ctrl_if.slave bus
);
  if (DATA_WIDTH < 1 || SETTLE_WIDTH < 1 || PERIOD_WIDTH < 1) begin : g_bad_width
    $error("signal_switch_ctrl: widths must be positive");
  end

  state_e                  r_state, w_next;
  logic                    r_switch, r_blank, r_tgt, r_ready_en;
  logic [SETTLE_WIDTH-1:0] r_settle, r_cnt;
  logic [COUNT_WIDTH-1:0]  r_switch_count;
  logic                    w_ready, w_int, w_acc, w_sel, w_change;

  // r_ready_en keeps req_ready low on the cycle right after a reset edge.
  assign w_ready = (r_state == ST_IDLE) && r_ready_en;

`ifdef SIGNAL_SWITCH_CTRL_AUTO_EN
  logic w_fire;
  switch_period_timer #(.PERIOD_WIDTH(PERIOD_WIDTH)) u_timer (
    .i_clk    (SYS_aclk),
    .i_rst    (SYS_reset),
    .i_en     (bus.auto_en && w_ready),
    .i_clr    (w_acc),
    .i_period (bus.auto_period),
    .o_fire   (w_fire)
  );
  // An external request in the same cycle takes precedence.
  assign w_int = w_fire && w_ready && !bus.req_valid;
`else
  assign w_int = 1'b0;
`endif

  assign w_acc    = (bus.req_valid && w_ready) || w_int;
  assign w_sel    = bus.req_valid ? bus.req_sel : ~r_switch;
  assign w_change = w_acc && (w_sel != r_switch);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_change) w_next = ST_ARM;
      ST_ARM:    w_next = ST_SETTLE;
      ST_SETTLE: if (r_cnt == '0) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge SYS_aclk) begin
    if (SYS_reset) r_state <= ST_IDLE;
    else           r_state <= w_next;
  end

  always_ff @(posedge SYS_aclk) begin
    if (SYS_reset) begin
      r_switch       <= 1'b0;
      r_blank        <= 1'b0;
      r_tgt          <= 1'b0;
      r_ready_en     <= 1'b0;
      r_settle       <= '0;
      r_cnt          <= '0;
      r_switch_count <= '0;
    end else begin
      r_ready_en <= 1'b1;
      case (r_state)
        ST_IDLE: if (w_change) begin
          // Target and settle length are frozen here; later input changes are ignored.
          r_tgt    <= w_sel;
          r_settle <= bus.settle_cycles;
          r_blank  <= 1'b1;
        end
        ST_ARM: begin
          r_switch <= r_tgt;
          r_cnt    <= r_settle;
        end
        ST_SETTLE: begin
          if (r_cnt == '0) begin
            r_blank        <= 1'b0;
            r_switch_count <= r_switch_count + COUNT_WIDTH'(1);
          end else begin
            r_cnt <= r_cnt - SETTLE_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready    = w_ready;
  assign bus.switch       = r_switch;
  assign bus.blank        = r_blank;
  assign bus.busy         = (r_state != ST_IDLE);
  assign bus.switch_count = r_switch_count;
endmodule

// File: tb/tb_signal_switch_ctrl.sv
// Testbench for signal_switch_ctrl. The reference model is a timeline view:
// an accepted change blanks for 2+settle cycles, with switch flipping one
// cycle after acceptance; everything is sampled 1 time unit after each edge.
module tb_signal_switch_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  logic        m_switch = 1'b0;
  logic [15:0] m_count  = '0;

  signal_switch_ctrl_if #(.SETTLE_WIDTH(16), .PERIOD_WIDTH(32)) bus ();

  signal_switch_ctrl #(.DATA_WIDTH(16), .SETTLE_WIDTH(16), .PERIOD_WIDTH(32)) dut (
    .SYS_aclk  (clk),
    .SYS_reset (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {switch, blank, busy, req_ready}
  function automatic logic [3:0] obs();
    return {bus.switch, bus.blank, bus.busy, bus.req_ready};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    n_chk++; if (obs() !== 4'b0000) begin n_fail++; $display("FAIL reset_outputs: got %b exp 0000", obs()); end
    n_chk++; if (bus.switch_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d exp 0", bus.switch_count); end
    rst = 1'b0;
    step();
    n_chk++; if (obs() !== 4'b0001) begin n_fail++; $display("FAIL reset_release_ready: got %b exp 0001", obs()); end
    m_switch = 1'b0; m_count = '0;
  endtask

  // settle=3: blank for 5 cycles, switch=1 after N+1, idle after N+5.
  task automatic test_basic();
    int nblank = 0;
    bus.req_valid = 1'b1; bus.req_sel = 1'b1; bus.settle_cycles = 16'd3;
    step();
    bus.req_valid = 1'b0; bus.settle_cycles = 16'd9; // must not affect this op
    nblank += int'(bus.blank);
    n_chk++; if (obs() !== 4'b0110) begin n_fail++; $display("FAIL basic_arm: got %b exp 0110", obs()); end
    for (int k = 1; k <= 4; k++) begin
      step();
      nblank += int'(bus.blank);
      n_chk++; if (obs() !== 4'b1110) begin n_fail++; $display("FAIL basic_settle%0d: got %b exp 1110", k, obs()); end
    end
    step();
    nblank += int'(bus.blank);
    n_chk++; if (obs() !== 4'b1001) begin n_fail++; $display("FAIL basic_done: got %b exp 1001", obs()); end
    n_chk++; if (bus.switch_count !== 16'd1) begin n_fail++; $display("FAIL basic_count: got %0d exp 1", bus.switch_count); end
    n_chk++; if (nblank != 5) begin n_fail++; $display("FAIL basic_blank_len: got %0d exp 5", nblank); end
    m_switch = 1'b1; m_count = 16'd1;
  endtask

  task automatic test_noop();
    bus.req_valid = 1'b1; bus.req_sel = 1'b1; bus.settle_cycles = 16'd4;
    step();
    bus.req_valid = 1'b0;
    n_chk++; if (obs() !== 4'b1001) begin n_fail++; $display("FAIL noop_state: got %b exp 1001", obs()); end
    step();
    n_chk++; if (obs() !== 4'b1001) begin n_fail++; $display("FAIL noop_state2: got %b exp 1001", obs()); end
    n_chk++; if (bus.switch_count !== m_count) begin n_fail++; $display("FAIL noop_count: got %0d exp %0d", bus.switch_count, m_count); end
  endtask

  // settle=0: 2 blank cycles; a second request held through ARM lands only in IDLE.
  task automatic test_zero_settle();
    bus.req_valid = 1'b1; bus.req_sel = 1'b0; bus.settle_cycles = 16'd0;
    step();
    bus.req_sel = 1'b1;
    n_chk++; if (obs() !== 4'b1110) begin n_fail++; $display("FAIL zero_arm: got %b exp 1110", obs()); end
    step();
    n_chk++; if (obs() !== 4'b0110) begin n_fail++; $display("FAIL zero_settle: got %b exp 0110", obs()); end
    step();
    n_chk++; if (obs() !== 4'b0001) begin n_fail++; $display("FAIL zero_idle: got %b exp 0001", obs()); end
    n_chk++; if (bus.switch_count !== 16'd2) begin n_fail++; $display("FAIL zero_count: got %0d exp 2", bus.switch_count); end
    step();
    bus.req_valid = 1'b0;
    n_chk++; if (obs() !== 4'b0110) begin n_fail++; $display("FAIL zero_second_accept: got %b exp 0110", obs()); end
    step(); step();
    n_chk++; if (obs() !== 4'b1001) begin n_fail++; $display("FAIL zero_second_done: got %b exp 1001", obs()); end
    n_chk++; if (bus.switch_count !== 16'd3) begin n_fail++; $display("FAIL zero_second_count: got %0d exp 3", bus.switch_count); end
    m_switch = 1'b1; m_count = 16'd3;
  endtask

  task automatic test_reset_mid();
    bus.req_valid = 1'b1; bus.req_sel = ~m_switch; bus.settle_cycles = 16'd10;
    step();
    bus.req_valid = 1'b0;
    step(); step(); step();
    n_chk++; if (bus.blank !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_blank: got %b exp 1", bus.blank); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_chk++; if (obs() !== 4'b0000) begin n_fail++; $display("FAIL midrst_outputs: got %b exp 0000", obs()); end
    n_chk++; if (bus.switch_count !== 16'd0) begin n_fail++; $display("FAIL midrst_count: got %0d exp 0", bus.switch_count); end
    step();
    n_chk++; if (obs() !== 4'b0001) begin n_fail++; $display("FAIL midrst_ready: got %b exp 0001", obs()); end
    m_switch = 1'b0; m_count = '0;
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      int idle_n, s;
      logic sel, old;
      idle_n = int'($urandom_range(0, 3));
      for (int i = 0; i < idle_n; i++) begin
        step();
        n_chk++; if (obs() !== {m_switch, 3'b001}) begin n_fail++; $display("FAIL rand_idle: got %b exp %b", obs(), {m_switch, 3'b001}); end
      end
      sel = 1'($urandom_range(0, 1));
      s   = int'($urandom_range(0, 5));
      bus.req_valid = 1'b1; bus.req_sel = sel; bus.settle_cycles = 16'(s);
      step();
      old = m_switch;
      if (sel == old) begin
        bus.req_valid = 1'b0;
        n_chk++; if (obs() !== {old, 3'b001}) begin n_fail++; $display("FAIL rand_noop: got %b exp %b", obs(), {old, 3'b001}); end
      end else begin
        for (int k = 1; k <= s + 2; k++) begin
          // Busy-time noise: requests are ignored and settle changes do not matter.
          bus.req_valid = 1'($urandom_range(0, 1));
          bus.req_sel = 1'($urandom_range(0, 1));
          bus.settle_cycles = 16'($urandom_range(0, 15));
          n_chk++; if (obs() !== {(k == 1) ? old : sel, 3'b110}) begin n_fail++; $display("FAIL rand_busy k=%0d s=%0d: got %b exp %b", k, s, obs(), {(k == 1) ? old : sel, 3'b110}); end
          step();
        end
        bus.req_valid = 1'b0;
        m_switch = sel; m_count = m_count + 16'd1;
        n_chk++; if (obs() !== {sel, 3'b001}) begin n_fail++; $display("FAIL rand_done: got %b exp %b", obs(), {sel, 3'b001}); end
      end
      n_chk++; if (bus.switch_count !== m_count) begin n_fail++; $display("FAIL rand_count: got %0d exp %0d", bus.switch_count, m_count); end
    end
  endtask

  // The counter is preset to 0xFFFF (as if after 65535 switches); one more wraps it.
  task automatic test_wrap();
    dut.r_switch_count = 16'hFFFF;
    bus.req_valid = 1'b1; bus.req_sel = ~m_switch; bus.settle_cycles = 16'd0;
    step();
    bus.req_valid = 1'b0;
    step(); step();
    m_switch = ~m_switch; m_count = 16'd0;
    n_chk++; if (bus.switch_count !== 16'd0) begin n_fail++; $display("FAIL wrap_count: got %0h exp 0", bus.switch_count); end
    n_chk++; if (obs() !== {m_switch, 3'b001}) begin n_fail++; $display("FAIL wrap_state: got %b exp %b", obs(), {m_switch, 3'b001}); end
  endtask

`ifdef SIGNAL_SWITCH_CTRL_AUTO_EN
  // period=8, settle=1: a change every 11 cycles; 4th trigger pre-empted by an
  // external no-op request, which restarts the period.
  task automatic test_auto();
    int nxt = 8, last_rise = -10, sw_t = -1, rises = 0;
    bit injected = 1'b0, inj_now;
    logic exp_sw = 1'b0, exp_blank;
    rst = 1'b1; step(); rst = 1'b0;
    bus.settle_cycles = 16'd1; bus.auto_period = 32'd8;
    step();
    bus.auto_en = 1'b1;
    for (int t = 1; t <= 70; t++) begin
      inj_now = (rises == 3) && !injected && (t == nxt);
      if (inj_now) begin bus.req_valid = 1'b1; bus.req_sel = exp_sw; end
      step();
      bus.req_valid = 1'b0;
      if (t == sw_t) exp_sw = ~exp_sw;
      if (inj_now) begin
        injected = 1'b1; nxt = t + 8;
      end else if (t == nxt) begin
        last_rise = t; nxt = t + 11; sw_t = t + 1; rises++;
      end
      exp_blank = (t >= last_rise) && (t <= last_rise + 2);
      n_chk++; if ({bus.switch, bus.blank} !== {exp_sw, exp_blank}) begin n_fail++; $display("FAIL auto_t%0d: got sw/blank %b exp %b", t, {bus.switch, bus.blank}, {exp_sw, exp_blank}); end
    end
    bus.auto_period = 32'd0;
    step(); step(); step(); step();
    for (int t = 0; t < 25; t++) begin
      step();
      n_chk++; if (bus.blank !== 1'b0) begin n_fail++; $display("FAIL auto_period0 t%0d: got blank %b exp 0", t, bus.blank); end
    end
    bus.auto_en = 1'b0;
    rst = 1'b1; step(); rst = 1'b0; step();
    m_switch = 1'b0; m_count = '0;
  endtask
`endif

  initial begin
    bus.req_valid = 1'b0; bus.req_sel = 1'b0; bus.settle_cycles = '0;
`ifdef SIGNAL_SWITCH_CTRL_AUTO_EN
    bus.auto_en = 1'b0; bus.auto_period = 32'd0;
`endif
    test_reset();
    test_basic();
    test_noop();
    test_zero_settle();
    test_reset_mid();
    test_random();
    test_wrap();
`ifdef SIGNAL_SWITCH_CTRL_AUTO_EN
    test_auto();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/signal_switch_ctrl.md
SIGNAL_SWITCH_CTRL -- requirements
Module: signal_switch_ctrl

Interface
- REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, giving the width of the controlled signal_switch datapath (informational, used for package alignment).
- REQ-002 The block SHALL have parameter SETTLE_WIDTH, default 16, giving the width of the settle-cycle count.
- REQ-003 The block SHALL have parameter PERIOD_WIDTH, default 32, giving the width of the auto-toggle period.
- REQ-004 SYS_aclk  in  1  sole clock; all logic on rising edge.
- REQ-005 SYS_reset  in  1  synchronous, active-high reset.
- REQ-006 req_valid  in  1  switch request strobe.
- REQ-007 req_sel  in  1  requested source: 0 = a, 1 = b.
- REQ-008 req_ready  out  1  request accepted on the cycle where req_valid and req_ready are both 1.
- REQ-009 settle_cycles  in  SETTLE_WIDTH  extra blanking cycles after a source change.
- REQ-010 switch  out  1  select line driving signal_switch.
- REQ-011 blank  out  1  downstream data invalid while 1.
- REQ-012 busy  out  1  1 in any state other than IDLE.
- REQ-013 switch_count  out  16  completed source changes; wraps 0xFFFF -> 0.
- REQ-014 auto_en  in  1, and auto_period  in  PERIOD_WIDTH, SHALL exist only when SIGNAL_SWITCH_CTRL_AUTO_EN is defined.

Function
- REQ-015 FSM states: IDLE, ARM, SETTLE.
- REQ-016 IDLE: req_ready = 1, busy = 0, blank = 0.
- REQ-017 Accept in IDLE with req_sel == switch: no-op; state stays IDLE; switch_count unchanged.
- REQ-018 Accept at edge N with req_sel != switch: latch target and settle_cycles; after edge N, state = ARM and blank = 1.
- REQ-019 ARM, edge N+1: switch <= target; counter <= latched settle value; state -> SETTLE.
- REQ-020 SETTLE: at each edge, if counter == 0, then state -> IDLE, blank <= 0, and switch_count increments; otherwise counter decrements.
- REQ-021 Blank-high duration SHALL be exactly 2 + settle_cycles cycles; switch SHALL change only while blank = 1.
- REQ-022 req_ready = 0 in ARM and SETTLE; req_valid there is ignored and not queued.
- REQ-023 settle_cycles changes after acceptance SHALL NOT affect the operation in progress.

Reset
- REQ-024 While SYS_reset = 1 on an edge, outputs after that edge SHALL be: state IDLE, switch 0, blank 0, busy 0, switch_count 0, req_ready 0, counters 0.
- REQ-025 Reset in ARM or SETTLE SHALL abort immediately with no count increment; req_ready returns to 1 on the first edge after SYS_reset falls.

Configuration
- REQ-026 With SIGNAL_SWITCH_CTRL_AUTO_EN defined and auto_en = 1 in IDLE, a period counter SHALL increment each cycle; on reaching auto_period - 1, it SHALL issue an internal request with target = !switch, sequenced exactly as REQ-018 to REQ-021.
- REQ-027 An external req_valid in the same cycle SHALL take priority over the internal request.
- REQ-028 The period counter SHALL clear on any accepted request, in non-IDLE states, and whenever auto_en = 0.
- REQ-029 auto_period = 0 SHALL disable auto toggling.
- REQ-030 Without the macro, auto ports and logic SHALL be absent; behaviour is external-request only.

Structure
- REQ-031 Package signal_switch_pkg SHALL hold the FSM state enum and default DATA_WIDTH, SETTLE_WIDTH and PERIOD_WIDTH constants.
- REQ-032 Auto-toggle timing SHALL reside in sub-module switch_period_timer, instantiated only under the macro.

Verification
- REQ-033 Reset, then req_sel = 1, settle_cycles = 3 at edge N: blank high for 5 cycles; switch = 1 after edge N+1; switch_count = 1; busy = 0 after edge N+5.
- REQ-034 switch = 1, request req_sel = 1: no blank, switch_count unchanged, req_ready stays 1.
- REQ-035 settle_cycles = 0: blank high for exactly 2 cycles; a second req_valid held during ARM is not accepted until IDLE.
- REQ-036 Assert SYS_reset for 1 cycle mid-SETTLE with settle_cycles = 10: switch 0, blank 0, switch_count 0 on the next cycle.
- REQ-037 Macro defined, auto_en = 1, auto_period = 8, settle_cycles = 1: switch toggles every 8 + 3 cycles; an external request in the trigger cycle wins.
- REQ-038 Preload switch_count = 0xFFFF through 65535 switches, one more switch: switch_count = 0.
